// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory loader.
//  Revision    : 1.0
// ============================================================================
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_PC  = 3'd1,
        ST_HDR_LEN = 3'd2,
        ST_LOAD    = 3'd3,
        ST_FLUSH   = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

    localparam int c_BYTES_PER_WORD = 4;

    // Position of each header word at the start of the byte stream
    localparam int c_HDR_PC_IDX  = 0;
    localparam int c_HDR_LEN_IDX = 1;

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Byte-stream input and instruction-memory write port bundle.
//  Revision    : 1.0
// ============================================================================
interface imem_loader_if;
    logic        InValid;
    logic [7:0]  InData;
    logic        InReady;
    logic        IMemWrEn;
    logic [31:0] IMemWrAddr;
    logic [31:0] IMemWrData;

    // master: stream source / memory side; slave: the loader
    modport master (
        output InValid, InData,
        input  InReady, IMemWrEn, IMemWrAddr, IMemWrData
    );
    modport slave (
        input  InValid, InData,
        output InReady, IMemWrEn, IMemWrAddr, IMemWrData
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader_byte_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : byte_word_assembler
//  Description : Packs MSB-first bytes into 32-bit words, flags each 4th byte.
//  Revision    : 1.0
// ============================================================================
module byte_word_assembler
    import imem_loader_pkg::*;
(
    input  wire logic        CLK,
    input  wire logic        Reset_L,
    input  wire logic        clear,
    input  wire logic        byte_valid,
    input  wire logic [7:0]  byte_data,
    output logic             word_valid,
    output logic [31:0]      word_data
);

    localparam logic [1:0] c_LAST_BYTE = 2'(c_BYTES_PER_WORD - 1);

    // Only the first three bytes need storage; the 4th is used as it arrives
    // so the word is available on the same edge that accepts it.
    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_shift <= 24'd0;
            r_cnt   <= 2'd0;
        end else if (clear) begin
            r_cnt   <= 2'd0;
        end else if (byte_valid) begin
            r_shift <= {r_shift[15:0], byte_data};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    assign word_valid = byte_valid && (r_cnt == c_LAST_BYTE);
    assign word_data  = {r_shift, byte_data};

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot loader writing a header-framed byte stream into IMEM.
//  Revision    : 1.0
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  wire logic     CLK,
    input  wire logic     Reset_L,
    input  wire logic     Start,
    imem_loader_if.slave  bus,
    output logic          ProcReset_L,
    output logic [31:0]   StartPC,
    output logic          Busy,
    output logic          Done,
    output logic          Error
);

    localparam logic [32:0] c_MAX_WORDS = 33'd1 << ADDR_WIDTH;

    state_t                  r_state, w_state_next;
    logic [31:0]             r_start_pc;
    logic [31:0]             r_addr;
    logic [ADDR_WIDTH-1:0]   r_word_cnt;
    logic [ADDR_WIDTH-1:0]   r_last_idx;
    logic                    r_wr_en;
    logic [31:0]             r_wr_addr;
    logic [31:0]             r_wr_data;

    logic                    w_asm_clr, w_latch_pc, w_latch_len, w_write;
    logic                    w_in_ready, w_busy, w_done, w_error, w_proc_run;
    logic                    w_word_valid;
    logic [31:0]             w_word;

    byte_word_assembler u_asm (
        .CLK        (CLK),
        .Reset_L    (Reset_L),
        .clear      (w_asm_clr),
        .byte_valid (bus.InValid && w_in_ready),
        .byte_data  (bus.InData),
        .word_valid (w_word_valid),
        .word_data  (w_word)
    );

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_asm_clr    = 1'b0;
        w_latch_pc   = 1'b0;
        w_latch_len  = 1'b0;
        w_write      = 1'b0;
        w_in_ready   = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_error      = 1'b0;
        w_proc_run   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                w_done     = (r_state == ST_DONE);
                w_proc_run = (r_state == ST_DONE);
                w_error    = (r_state == ST_ERROR);
                if (Start) begin
                    w_state_next = ST_HDR_PC;
                    w_asm_clr    = 1'b1;
                end
            end
            ST_HDR_PC: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (w_word_valid) begin
                    w_latch_pc   = 1'b1;
                    w_state_next = (w_word[1:0] != 2'b00) ? ST_ERROR : ST_HDR_LEN;
                end
            end
            ST_HDR_LEN: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (w_word_valid) begin
                    if (w_word == 32'd0) begin
                        w_state_next = ST_FLUSH;
                    end else if ({1'b0, w_word} > c_MAX_WORDS) begin
                        w_state_next = ST_ERROR;
                    end else begin
                        w_latch_len  = 1'b1;
                        w_state_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (w_word_valid) begin
                    w_write = 1'b1;
                    if (r_word_cnt == r_last_idx) w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_busy       = 1'b1;
                w_state_next = ST_DONE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // N is stored as N-1 so a full 2**ADDR_WIDTH load fits the counter width
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_start_pc <= 32'd0;
            r_addr     <= 32'd0;
            r_word_cnt <= '0;
            r_last_idx <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= 32'd0;
            r_wr_data  <= 32'd0;
        end else begin
            r_wr_en <= w_write;
            if (w_latch_pc) r_start_pc <= w_word;
            if (w_latch_len) begin
                r_addr     <= r_start_pc;
                r_word_cnt <= '0;
                r_last_idx <= ADDR_WIDTH'(w_word - 32'd1);
            end
            if (w_write) begin
                r_wr_addr  <= r_addr;
                r_wr_data  <= w_word;
                r_addr     <= r_addr + 32'(c_BYTES_PER_WORD);
                r_word_cnt <= r_word_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    assign bus.InReady    = w_in_ready;
    assign bus.IMemWrEn   = r_wr_en;
    assign bus.IMemWrAddr = r_wr_addr;
    assign bus.IMemWrData = r_wr_data;
    assign ProcReset_L    = w_proc_run;
    assign StartPC        = r_start_pc;
    assign Busy           = w_busy;
    assign Done           = w_done;
    assign Error          = w_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for the IMEM boot loader.
//  Revision    : 1.0
// ============================================================================
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic        Start = 1'b0;
    logic        ProcReset_L;
    logic [31:0] StartPC;
    logic        Busy, Done, Error;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          strobe_cnt = 0;
    logic [31:0] pay [0:255];

    imem_loader_if bus ();

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .CLK         (CLK),
        .Reset_L     (Reset_L),
        .Start       (Start),
        .bus         (bus),
        .ProcReset_L (ProcReset_L),
        .StartPC     (StartPC),
        .Busy        (Busy),
        .Done        (Done),
        .Error       (Error)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (bus.IMemWrEn === 1'b1) strobe_cnt <= strobe_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit thr);
        int n = 0;
        if (thr) begin
            int g = $urandom_range(0, 2);
            bus.InValid = 1'b0;
            repeat (g) begin @(posedge CLK); #1; end
        end
        bus.InValid = 1'b1;
        bus.InData  = b;
        while (bus.InReady !== 1'b1 && n < 20) begin @(posedge CLK); #1; n++; end
        if (n == 20) chk("in_ready_timeout", 32'(bus.InReady), 32'd1);
        @(posedge CLK); #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit thr);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], thr);
        bus.InValid = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0;
        chk("start_inready", 32'(bus.InReady), 32'd1);
        chk("start_busy",    32'(Busy),        32'd1);
        chk("start_error",   32'(Error),       32'd0);
        chk("start_prst",    32'(ProcReset_L), 32'd0);
    endtask

    task automatic do_load(input logic [31:0] pc, input int n, input bit thr, input bit hold);
        int base;
        base = strobe_cnt;
        pulse_start();
        send_word(pc, thr);
        send_word(32'(n), thr);
        if (n == 0) chk("zero_no_strobe", 32'(bus.IMemWrEn), 32'd0);
        for (int i = 0; i < n; i++) begin
            if (hold && i == 0) Start = 1'b1;
            send_word(pay[i], thr);
            Start = 1'b0;
            chk("wr_en",   32'(bus.IMemWrEn), 32'd1);
            chk("wr_addr", bus.IMemWrAddr,    pc + 32'(4 * i));
            chk("wr_data", bus.IMemWrData,    pay[i]);
        end
        chk("flush_busy", 32'(Busy), 32'd1);
        chk("flush_done", 32'(Done), 32'd0);
        @(posedge CLK); #1;
        chk("done_flag",    32'(Done),          32'd1);
        chk("done_prst",    32'(ProcReset_L),   32'd1);
        chk("done_startpc", StartPC,            pc);
        chk("done_busy",    32'(Busy),          32'd0);
        chk("done_inready", 32'(bus.InReady),   32'd0);
        chk("strobe_count", 32'(strobe_cnt - base), 32'(n));
    endtask

    task automatic do_err(input logic [31:0] pc, input logic [31:0] n);
        pulse_start();
        send_word(pc, 1'b0);
        if (pc[1:0] == 2'b00) send_word(n, 1'b0);
        chk("err_flag",    32'(Error),         32'd1);
        chk("err_prst",    32'(ProcReset_L),   32'd0);
        chk("err_inready", 32'(bus.InReady),   32'd0);
        chk("err_busy",    32'(Busy),          32'd0);
        bus.InValid = 1'b1;
        bus.InData  = 8'hFF;
        repeat (2) begin @(posedge CLK); #1; end
        bus.InValid = 1'b0;
        chk("err_sticky",  32'(Error),         32'd1);
    endtask

    task automatic set_nominal();
        pay[0] = 32'h2008_0005;
        pay[1] = 32'h2009_0007;
        pay[2] = 32'h0109_5020;
    endtask

    initial begin
        bus.InValid = 1'b0;
        bus.InData  = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_inready", 32'(bus.InReady), 32'd0);
        chk("rst_wren",    32'(bus.IMemWrEn), 32'd0);
        chk("rst_wraddr",  bus.IMemWrAddr,    32'd0);
        chk("rst_wrdata",  bus.IMemWrData,    32'd0);
        chk("rst_prst",    32'(ProcReset_L),  32'd0);
        chk("rst_startpc", StartPC,           32'd0);
        chk("rst_busy",    32'(Busy),         32'd0);
        chk("rst_done",    32'(Done),         32'd0);
        chk("rst_error",   32'(Error),        32'd0);
        @(negedge CLK) Reset_L = 1'b1;
        @(posedge CLK); #1;
        chk("idle_inready", 32'(bus.InReady), 32'd0);

        // Nominal three-word program at address 0
        set_nominal();
        do_load(32'h0000_0000, 3, 1'b0, 1'b0);

        // Nonzero base; Start held high during LOAD must be ignored
        pay[0] = 32'hDEAD_BEEF;
        pay[1] = 32'h1234_5678;
        do_load(32'h0000_0040, 2, 1'b0, 1'b1);

        // Empty program
        do_load(32'h0000_0100, 0, 1'b0, 1'b0);

        // Header rejections
        do_err(32'h0000_0042, 32'd0);
        do_err(32'h0000_0000, 32'h0000_0101);

        // Largest legal program
        for (int i = 0; i < 256; i++) pay[i] = {8'(i), 8'(~i), 16'hC0DE};
        do_load(32'h0000_1000, 256, 1'b0, 1'b0);

        // Throttled nominal stream
        set_nominal();
        do_load(32'h0000_0000, 3, 1'b1, 1'b0);

        // Reset asserted after the 2nd payload byte
        pulse_start();
        send_word(32'h0000_0080, 1'b0);
        send_word(32'd3, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        Reset_L = 1'b0;
        bus.InValid = 1'b0;
        #1;
        chk("mid_rst_inready", 32'(bus.InReady), 32'd0);
        chk("mid_rst_busy",    32'(Busy),        32'd0);
        chk("mid_rst_prst",    32'(ProcReset_L), 32'd0);
        chk("mid_rst_startpc", StartPC,          32'd0);
        chk("mid_rst_wraddr",  bus.IMemWrAddr,   32'd0);
        chk("mid_rst_wrdata",  bus.IMemWrData,   32'd0);
        @(negedge CLK) Reset_L = 1'b1;
        @(posedge CLK); #1;
        do_load(32'h0000_0080, 3, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
